// File: rtl/seq_serializer.sv
// seq_serializer
//   Parallel-to-serial front end for the 1010 sequence detector. Words are
//   taken over a valid/ready handshake and shifted out one bit per cycle in
//   which bit_en is high. A one-word holding buffer lets consecutive words
//   run with no idle bit between them.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   data_in       word to serialize
//   data_valid    data_in is valid this cycle
//   data_ready    a word can be accepted this cycle (combinational)
//   bit_en        bit-rate strobe; the current bit is consumed only when high
//   serial_out    serial bit to the detector's din (0 between frames)
//   serial_valid  serial_out carries a word bit
//   last_bit      serial_out is the final bit of the current word
//   words_sent    count of fully shifted words, wraps at 16 bits
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic [15:0]      words_sent
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic             accept;
    logic             complete;

    // Move the register one place toward the output end, filling with 0.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
        if (MSB_FIRST != 0) begin
            return {s[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, s[WIDTH-1:1]};
        end
    endfunction

    assign data_ready   = reset && !hold_full;
    assign accept       = data_valid && data_ready;
    assign complete     = (state == SHIFT) && bit_en && (cnt == LAST_IDX);

    assign serial_valid = (state == SHIFT);
    assign serial_out   = (state == SHIFT) ? shreg[OUT_IDX] : 1'b0;
    assign last_bit     = serial_valid && (cnt == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Stay in SHIFT if another word is buffered or arrives right now.
                if (complete && !hold_full && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            words_sent <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // The buffer is bypassed when nothing is shifting.
                    if (accept) begin
                        shreg <= data_in;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (complete) begin
                        words_sent <= words_sent + 16'd1;
                        if (hold_full) begin
                            shreg     <= hold_reg;
                            cnt       <= '0;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            // Word arriving on the completion edge goes
                            // straight into the shifter so no gap appears.
                            shreg <= data_in;
                            cnt   <= '0;
                        end
                    end else begin
                        if (bit_en) begin
                            shreg <= shift_out(shreg);
                            cnt   <= cnt + CNT_W'(1);
                        end
                        if (accept) begin
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding buffer carries data only; its contents are qualified by hold_full.
    always_ff @(posedge clock) begin
        if (accept && (state == SHIFT) && !complete) begin
            hold_reg <= data_in;
        end
    end

endmodule
